// File: rtl/hash_pkg.sv
// Shared constants and FSM encoding for the multiplicative (h*33 + word) hash engine.
package hash_pkg;
    localparam int          WORD_W   = 32;
    localparam logic [31:0] SEED_DEF = 32'd5381;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_MIX  = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;
endpackage

// File: rtl/hash_engine_add.sv
// 32-bit combinational adder; the carry out is dropped so sums wrap modulo 2^32.
module hash_engine_add
    import hash_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic [WORD_W-1:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

// File: rtl/hash_engine.sv
// Word-serial hash: h = h*33 + word, split into a MIX (h + h<<5) and an ACC (+word)
// cycle that share a single adder.
module hash_engine
    import hash_pkg::*;
#(
    parameter logic [31:0] SEED = SEED_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [WORD_W-1:0] DataIn,
    input  logic              DataValid,
    input  logic              DataLast,
    output logic              DataReady,
    output logic              Busy,
    output logic              Done,
    output logic [WORD_W-1:0] HashOut
);
    state_t            state_q, state_d;
    logic [WORD_W-1:0] h_q, h_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic [WORD_W-1:0] add_a, add_b, add_sum;

    hash_engine_add u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_sum)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        word_d    = word_q;
        last_d    = last_q;
        add_a     = h_q;
        add_b     = h_q << 5;
        DataReady = 1'b0;
        Done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    h_d     = SEED;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                DataReady = 1'b1;
                if (DataValid) begin
                    word_d  = DataIn;
                    last_d  = DataLast;
                    state_d = S_MIX;
                end
            end
            S_MIX: begin
                h_d     = add_sum;
                state_d = S_ACC;
            end
            S_ACC: begin
                // Second pass through the shared adder adds the latched word.
                add_b   = word_q;
                h_d     = add_sum;
                state_d = last_q ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy    = (state_q != S_IDLE);
    assign HashOut = h_q;
endmodule

// File: tb/tb_hash_engine.sv
// Randomized bench for hash_engine; two instances (default seed and all-ones seed) share stimulus.
module tb_hash_engine;
    import hash_pkg::*;

    localparam logic [31:0] SEED_S = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        Reset, Start, DataValid, DataLast;
    logic [31:0] DataIn;
    logic        rdy, busy, done, rdy_s, busy_s, done_s;
    logic [31:0] hout, hout_s;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hash_engine dut (
        .Clk(clk), .Reset(Reset), .Start(Start), .DataIn(DataIn),
        .DataValid(DataValid), .DataLast(DataLast), .DataReady(rdy),
        .Busy(busy), .Done(done), .HashOut(hout)
    );

    hash_engine #(.SEED(SEED_S)) dut_s (
        .Clk(clk), .Reset(Reset), .Start(Start), .DataIn(DataIn),
        .DataValid(DataValid), .DataLast(DataLast), .DataReady(rdy_s),
        .Busy(busy_s), .Done(done_s), .HashOut(hout_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_hash(input logic [31:0] seed, input logic [31:0] w[$]);
        logic [31:0] h;
        h = seed;
        foreach (w[i]) h = h * 32'd33 + w[i];
        return h;
    endfunction

    // All driving and sampling happens on the falling edge.
    task automatic run_msg(input logic [31:0] w[$], input bit noise);
        logic [31:0] e0, e1;
        e0 = ref_hash(SEED_DEF, w);
        e1 = ref_hash(SEED_S, w);
        Start     = 1'b1;
        DataValid = 1'($urandom_range(0, 1));
        DataIn    = $urandom;
        DataLast  = 1'b1;
        @(negedge clk);
        Start     = 1'b0;
        DataValid = 1'b0;
        chk("wait_rdy", 32'(rdy), 32'd1);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("seed_load", hout, SEED_DEF);
        chk("seed_load_s", hout_s, SEED_S);
        foreach (w[i]) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("stall_rdy", 32'(rdy), 32'd1);
                chk("stall_busy", 32'(busy), 32'd1);
            end
            DataValid = 1'b1;
            DataIn    = w[i];
            DataLast  = (i == w.size() - 1);
            @(negedge clk);
            DataValid = 1'($urandom_range(0, 1));
            DataIn    = $urandom;
            DataLast  = 1'($urandom_range(0, 1));
            chk("mix_rdy", 32'(rdy), 32'd0);
            @(negedge clk);
            chk("acc_rdy", 32'(rdy), 32'd0);
            chk("acc_done", 32'(done), 32'd0);
            if (noise) Start = 1'b1;
            @(negedge clk);
            Start     = 1'b0;
            DataValid = 1'b0;
            if (i == w.size() - 1) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_rdy", 32'(rdy), 32'd0);
                chk("hash", hout, e0);
                chk("hash_s", hout_s, e1);
            end else begin
                chk("back_rdy", 32'(rdy), 32'd1);
                chk("mid_done", 32'(done), 32'd0);
            end
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("hold", hout, e0);
    endtask

    initial begin
        logic [31:0] q[$];
        Reset = 1'b1; Start = 1'b0; DataValid = 1'b0; DataLast = 1'b0; DataIn = '0;
        repeat (2) @(negedge clk);
        chk("rst_hash", hout, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        Reset = 1'b0;
        @(negedge clk);

        q = {32'h61};
        run_msg(q, 1'b0);
        chk("single_61", hout, 32'h0002_B606);

        q = {32'h61, 32'h62};
        run_msg(q, 1'b0);
        chk("two_word", hout, 32'h0059_7728);

        q = {32'h61, 32'h62};
        run_msg(q, 1'b1);
        chk("start_in_acc", hout, 32'h0059_7728);

        q = {32'h1};
        run_msg(q, 1'b0);
        chk("wrap", hout_s, 32'hFFFF_FFE0);

        // Reset in MIX of a two-word message.
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; DataValid = 1'b1; DataIn = 32'h61; DataLast = 1'b0;
        @(negedge clk);
        DataValid = 1'b0;
        chk("pre_rst_mix", 32'(rdy), 32'd0);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("mrst_hash", hout, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_rdy", 32'(rdy), 32'd0);
        q = {32'h61};
        run_msg(q, 1'b0);
        chk("after_rst", hout, 32'h0002_B606);

        repeat (20) begin
            q = {};
            repeat ($urandom_range(1, 6)) q.push_back($urandom);
            run_msg(q, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hash_engine.md
HASH_ENGINE -- requirements
Module: hash_engine

Interface
REQ-001 SHALL have parameter SEED, default 32'd5381, initial hash value loaded on Start.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  begin new message; sampled only in IDLE.
REQ-005 SHALL have port DataIn  input  32  message word.
REQ-006 SHALL have port DataValid  input  1  DataIn/DataLast valid.
REQ-007 SHALL have port DataLast  input  1  marks final word of message.
REQ-008 SHALL have port DataReady  output  1  engine accepts a word this cycle.
REQ-009 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port Done  output  1  one-cycle pulse, HashOut final.
REQ-011 SHALL have port HashOut  output  32  current/final hash register.

Function
REQ-012 SHALL compute per word: h = h*33 + word, as h + (h<<5) then + word; all sums modulo 2^32, carries discarded.
REQ-013 SHALL implement states IDLE, WAIT, MIX, ACC, DONE.
REQ-014 IDLE: DataReady=0, Busy=0; Start=1 -> h<=SEED, go WAIT.
REQ-015 WAIT: DataReady=1; DataValid=1 -> latch DataIn and DataLast into internal registers, go MIX; else stay.
REQ-016 MIX: h <= h + (h<<5), go ACC; DataReady=0.
REQ-017 ACC: h <= h + latched word; latched last=1 -> DONE, else -> WAIT; DataReady=0.
REQ-018 DONE: Done=1 for exactly this cycle, go IDLE.
REQ-019 Word handshake SHALL complete only when DataValid and DataReady are both 1 on the same edge; DataIn changes while DataReady=0 SHALL be ignored.
REQ-020 Throughput SHALL be one word per 3 cycles minimum; Done SHALL assert 3 cycles after the last word's accept edge.
REQ-021 Start asserted outside IDLE SHALL be ignored, current message unaffected.
REQ-022 Start and DataValid asserted together in IDLE SHALL only start; the word SHALL be accepted no earlier than the following WAIT cycle.
REQ-023 HashOut SHALL equal h at all times and hold the final value from DONE until the next accepted Start.
REQ-024 Zero-word messages are not supported; the engine SHALL remain in WAIT until a word arrives.

Reset
REQ-025 Reset=1 at a rising edge SHALL force IDLE, HashOut=0, Done=0, DataReady=0, Busy=0 and clear latched word/last, from any state including mid-message.
REQ-026 Reset SHALL take priority over Start and DataValid on the same edge.

Structure
REQ-027 State encodings, SEED default and word width (32) SHALL live in a shared package hash_pkg.
REQ-028 Both additions SHALL use one time-multiplexed instance of the team's 32-bit combinational Add module, operands selected by state (MIX: h, h<<5; ACC: h, word).
REQ-029 No other sub-modules; FSM, hash, word and last registers SHALL be local.

Verification
REQ-030 Single word 0x00000061, SEED default, DataLast=1 -> Done pulse, HashOut=0x0002B606.
REQ-031 Two words 0x61 then 0x62 (last on second) -> HashOut=0x00597728, DataReady high only in WAIT cycles.
REQ-032 SEED=0xFFFFFFFF, single word 0x00000001 -> HashOut=0xFFFFFFE0 (wrap-around).
REQ-033 DataValid held low 5 cycles in WAIT, then 0x61 -> engine stalls without state change, final HashOut=0x0002B606.
REQ-034 Reset asserted in MIX of a 2-word message -> next cycle IDLE, HashOut=0, Done=0; new Start with 0x61 -> 0x0002B606.
REQ-035 Start pulsed during ACC -> ignored; result identical to REQ-031 run.
